datapath_seq: RTL
=================

Name: datapath_seq

Overview:
- Parametrised successor to the 16-bit/8-register datapath.
- Adds an internal sequencer FSM, so one command plus a start pulse runs a whole operation with no external load/select strobes: operand fetch, shift, ALU, writeback.
- Adds N/V/Z status flags.
- Sits between the instruction controller (next lab) and the register file; a debug read port serves the benches.

Parameters:
- DW, 16, datapath/register width in bits (>=4).
- NREG, 8, number of general registers (power of 2, >=2).
- RW, $clog2(NREG), register index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command valid; sampled only in IDLE
- opcode  in  3  command code (see Behaviour)
- rd  in  RW  destination register
- rn  in  RW  A-operand register
- rm  in  RW  B-operand register (shifted)
- shift  in  2  B shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
- imm  in  DW  immediate for MOVI
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse, command complete
- result  out  DW  C register (last ALU result)
- flag_z  out  1  zero flag
- flag_n  out  1  negative flag
- flag_v  out  1  signed overflow flag
- dbg_sel  in  RW  debug read index
- dbg_data  out  DW  combinational read of register dbg_sel

Behaviour:
- Reset (async, rst_n=0): all registers, A, B and C clear to 0; flags clear to 0; busy=0, done=0; FSM enters IDLE. This applies mid-command too: the command is abandoned and no partial writeback occurs.
- Command latch: opcode, rd, rn, rm, shift and imm are latched on the edge where IDLE and start=1. Inputs may then change freely.
- start while busy: ignored; no queuing.
- Opcodes:
  - 000 MOVI: Rd=imm.
  - 001 MOV: Rd=sh(Rm).
  - 010 ADD: Rd=Rn+sh(Rm).
  - 011 CMP: flags from Rn-sh(Rm), no register write.
  - 100 AND: Rd=Rn&sh(Rm).
  - 101 MVN: Rd=~sh(Rm).
  - 110/111: illegal; go straight to DONE with no state change.
- FSM states: IDLE, GET_A, GET_B, EXEC, WB, DONE. One cycle per non-IDLE state.
  - MOVI: IDLE->WB->DONE (writes imm).
  - MOV, MVN: IDLE->GET_B->EXEC->WB->DONE (A forced to 0).
  - ADD, AND: IDLE->GET_A->GET_B->EXEC->WB->DONE.
  - CMP: IDLE->GET_A->GET_B->EXEC->DONE.
  - DONE->IDLE unconditionally. done=1 only in DONE.
  - A new start may be sampled on the edge that leaves DONE (back-to-back).
- Datapath steps:
  - GET_A loads A=R[rn].
  - GET_B loads B=R[rm].
  - EXEC loads C=ALU(A, sh(B)). Shift is applied to B at EXEC.
  - WB writes R[rd]=C, or imm for MOVI.
  - Because operands are latched before WB, rd==rn==rm aliasing is safe.
- Arithmetic: DW-bit, carry discarded. CMP computes Rn - sh(Rm).
- Flags: updated only in EXEC of CMP; hold otherwise.
  - Z = (diff==0).
  - N = diff[DW-1].
  - V = (A[DW-1] != Bs[DW-1]) && (diff[DW-1] != A[DW-1]).
- result: holds C between commands. Unchanged by MOVI and illegal opcodes.
- dbg_data: combinational. A write lands at the WB edge and is visible immediately after.

Decomposition:
- datapath_pkg holds:
  - opcode_t enum (MOVI, MOV, ADD, CMP, AND, MVN).
  - shift_t enum (NONE, LSL, LSR, ASR).
  - state_t enum (the six FSM states).
- Sub-module dp_regfile: parametrised DW x NREG, one write port, two combinational read ports (operand and debug), async active-low clear.
- Shifter and ALU stay inline in datapath_seq.

Test Plan:
- MOVI R0,#7; MOVI R1,#2; ADD R2,R1,R0 LSL1 -> done after 5 busy cycles; R2=16 (dbg), result=16; R0=7, R1=2 unchanged.
- MOVI R3,#0; CMP R3,R1 LSR1 (R1=2) -> flag_n=1, flag_z=0, flag_v=0; no register changes; result=0xFFFF.
- MOVI R0,#0x7FFF; MOVI R1,#0x8000; CMP R0,R1 -> V=1, N=1, Z=0. Then CMP R0,R0 -> Z=1, N=0, V=0.
- MVN R5,R1 with R1=0x00F0, shift ASR1 -> R5=0xFF87. Pulse start with other fields during busy -> ignored, exactly one done.
- Assert rst_n low during EXEC of ADD R6,... -> busy/done 0 at once; R6 and all registers 0; flags 0. The next MOVI after release works.
- DW=8, NREG=4 build: MOVI R3,#0x80; ADD R2,R3,R3 -> R2=0x00 (wrap). Illegal opcode 111 -> done after 1 busy cycle, nothing changed.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared types for the sequenced datapath: command opcodes, B-operand shifts
// and the sequencer states.
package datapath_pkg;

    typedef enum logic [2:0] {
        OP_MOVI = 3'd0,
        OP_MOV  = 3'd1,
        OP_ADD  = 3'd2,
        OP_CMP  = 3'd3,
        OP_AND  = 3'd4,
        OP_MVN  = 3'd5
    } opcode_t;

    typedef enum logic [1:0] {
        SH_NONE = 2'd0,
        SH_LSL  = 2'd1,
        SH_LSR  = 2'd2,
        SH_ASR  = 2'd3
    } shift_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/dp_regfile.sv
// General register file: one write port, an operand read port and a debug
// read port, both combinational; asynchronous active-low clear.
module dp_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    localparam int RW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic [RW-1:0] dbg_sel,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata    = mem_q[raddr];
    assign dbg_data = mem_q[dbg_sel];

endmodule

// File: rtl/datapath_seq.sv
// Sequenced datapath: one start pulse runs fetch / shift+ALU / writeback for a
// latched command, with CMP-only N/V/Z flags and a debug register read port.
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 8,
    localparam int RW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    opcode,
    input  logic [RW-1:0] rd,
    input  logic [RW-1:0] rn,
    input  logic [RW-1:0] rm,
    input  logic [1:0]    shift,
    input  logic [DW-1:0] imm,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          flag_z,
    output logic          flag_n,
    output logic          flag_v,
    input  logic [RW-1:0] dbg_sel,
    output logic [DW-1:0] dbg_data
);

    state_t        state_q, state_d;
    logic [2:0]    opc_q, opc_d;
    logic [RW-1:0] rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
    logic [1:0]    sh_q, sh_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic          fz_q, fz_d, fn_q, fn_d, fv_q, fv_d;

    logic          accept, ld_a, ld_b, do_exec, rf_we;
    logic [RW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata, rf_wdata, b_sh, diff, alu_y;

    dp_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rd_q),
        .wdata   (rf_wdata),
        .raddr   (rf_raddr),
        .rdata   (rf_rdata),
        .dbg_sel (dbg_sel),
        .dbg_data(dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Entry point depends on which operands the opcode actually needs.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (opcode)
                        OP_MOVI:                state_d = S_WB;
                        OP_MOV, OP_MVN:         state_d = S_GET_B;
                        OP_ADD, OP_AND, OP_CMP: state_d = S_GET_A;
                        default:                state_d = S_DONE;
                    endcase
                end
            end
            S_GET_A: state_d = S_GET_B;
            S_GET_B: state_d = S_EXEC;
            S_EXEC:  state_d = (opc_q == OP_CMP) ? S_DONE : S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        accept   = (state_q == S_IDLE) && start;
        ld_a     = (state_q == S_GET_A);
        ld_b     = (state_q == S_GET_B);
        do_exec  = (state_q == S_EXEC);
        rf_we    = (state_q == S_WB);
        rf_raddr = ld_a ? rn_q : rm_q;
    end

    always_comb begin
        unique case (sh_q)
            SH_NONE: b_sh = b_q;
            SH_LSL:  b_sh = {b_q[DW-2:0], 1'b0};
            SH_LSR:  b_sh = {1'b0, b_q[DW-1:1]};
            SH_ASR:  b_sh = {b_q[DW-1], b_q[DW-1:1]};
            default: b_sh = b_q;
        endcase
        diff = a_q - b_sh;
        case (opc_q)
            OP_MOV:  alu_y = b_sh;
            OP_ADD:  alu_y = a_q + b_sh;
            OP_CMP:  alu_y = diff;
            OP_AND:  alu_y = a_q & b_sh;
            OP_MVN:  alu_y = ~b_sh;
            default: alu_y = c_q;
        endcase
        rf_wdata = (opc_q == OP_MOVI) ? imm_q : c_q;
    end

    always_comb begin
        opc_d = opc_q;
        rd_d  = rd_q;
        rn_d  = rn_q;
        rm_d  = rm_q;
        sh_d  = sh_q;
        imm_d = imm_q;
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        fz_d  = fz_q;
        fn_d  = fn_q;
        fv_d  = fv_q;
        if (accept) begin
            opc_d = opcode;
            rd_d  = rd;
            rn_d  = rn;
            rm_d  = rm;
            sh_d  = shift;
            imm_d = imm;
            if (opcode == OP_MOV || opcode == OP_MVN) begin
                a_d = '0;
            end
        end
        if (ld_a) a_d = rf_rdata;
        if (ld_b) b_d = rf_rdata;
        if (do_exec) begin
            c_d = alu_y;
            if (opc_q == OP_CMP) begin
                fz_d = (diff == '0);
                fn_d = diff[DW-1];
                fv_d = (a_q[DW-1] != b_sh[DW-1]) && (diff[DW-1] != a_q[DW-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q <= '0;
            rd_q  <= '0;
            rn_q  <= '0;
            rm_q  <= '0;
            sh_q  <= '0;
            imm_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            fz_q  <= 1'b0;
            fn_q  <= 1'b0;
            fv_q  <= 1'b0;
        end else begin
            opc_q <= opc_d;
            rd_q  <= rd_d;
            rn_q  <= rn_d;
            rm_q  <= rm_d;
            sh_q  <= sh_d;
            imm_q <= imm_d;
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            fz_q  <= fz_d;
            fn_q  <= fn_d;
            fv_q  <= fv_d;
        end
    end

    assign result = c_q;
    assign flag_z = fz_q;
    assign flag_n = fn_q;
    assign flag_v = fv_q;

endmodule
